dotmatrix_scan: RTL and testbench
=================================

Name: dotmatrix_scan

Overview:
Parametrised multiplexed scan driver for the board's dot-matrix LED. It generalises the fixed 8x8 anode/cathode pins to ROWS x COLS with selectable drive polarity. It adds a double-buffered frame store, per-row blanking to suppress ghosting, and global PWM brightness. It sits between the application logic, which writes rows into the back buffer, and the led_a*/led_k* pins in the board top-level.

Parameters:
ROWS, 8, number of anode lines (rows), >=2
COLS, 8, number of cathode lines (columns), >=1
BLANK, 16, clock cycles with all LEDs off at the start of each row slot, >=1
PWM_BITS, 4, brightness resolution; ON phase has 2**PWM_BITS steps
STEP, 64, clock cycles per PWM step, >=1
ANODE_ON, 1, anode level that selects a row
CATHODE_ON, 0, cathode level that lights a pixel

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write one row into the back buffer
wr_row  in  $clog2(ROWS)  target row index
wr_data  in  COLS  pixel bits, 1 = lit, bit c -> cathode c
swap_req  in  1  request front/back exchange at the next frame boundary
swap_ack  out  1  one-cycle pulse when the exchange is performed
brightness  in  PWM_BITS  0 = dark, 2**PWM_BITS-1 = maximum
anode  out  ROWS  row drive, one-hot ANODE_ON when active
cathode  out  COLS  column drive
frame_start  out  1  one-cycle pulse at the start of row 0 BLANK

Behaviour:
- Reset, synchronous and active-high: both buffers cleared to 0; row = 0; state = BLANK; step and cycle counters = 0; swap_pending = 0; front = buffer 0.
- Outputs during reset: anode all ~ANODE_ON, cathode all ~CATHODE_ON, swap_ack = 0, frame_start = 0.
- Reset asserted mid-operation takes effect on the next edge regardless of state.
- States:
  - BLANK (BLANK cycles): all outputs off.
  - ON (2**PWM_BITS * STEP cycles): then next row, back to BLANK.
- Row wraps from ROWS-1 to 0. Row slot = BLANK + 2**PWM_BITS*STEP cycles; frame = ROWS * row slot.
- brightness is sampled at the last BLANK cycle of each row. It holds for that row's ON phase.
- In ON step s (0..2**PWM_BITS-1), drive when s < sampled brightness:
  - anode[row] = ANODE_ON, other anodes off.
  - cathode[c] = CATHODE_ON where front[row][c] = 1, else ~CATHODE_ON.
- When s >= sampled brightness, all outputs are off. brightness 0 never lights; maximum gives a duty of (2**PWM_BITS-1)/2**PWM_BITS of the ON phase.
- Front buffer data is read at the start of each ON cycle. A row change only ever happens inside BLANK, so there is no overlap between rows.
- All outputs are registered: pins reflect the state of the previous cycle (1-cycle latency). The first BLANK cycle after reset release shows off.
- frame_start pulses for one cycle, aligned with the first output cycle of row 0 BLANK, including the first frame after reset.
- Writes:
  - wr_en with wr_row < ROWS writes the back buffer in one cycle.
  - wr_row >= ROWS is ignored.
  - The front buffer is never written.
- Swap:
  - swap_req sets swap_pending. Repeated requests while pending are absorbed (one swap).
  - The swap executes on the cycle row ROWS-1 ON ends. The front/back select toggles, swap_pending clears, and swap_ack pulses the following cycle. The new frame starts with the new front.
  - swap_req in the same cycle the swap executes sets pending again, so the next frame also swaps.
- Write in the same cycle as swap execution lands in the pre-swap back buffer, which becomes front, so the written data is displayed.
- The back buffer is not copied on swap. Software rewrites all rows before each request.

Decomposition:
- Package dotmatrix_pkg:
  - state enum {BLANK, ON}
  - helper function ROW_W = $clog2(ROWS) (min 1)
  - OFF-level constants derived from ANODE_ON/CATHODE_ON
- Sub-module dotmatrix_row_timer: BLANK/STEP/step counters, state, row index. Emits row_adv, frame_end, step index, phase.
- The top level holds both buffers, swap logic and output registers.

Test Plan:
Use ROWS=4, COLS=4, BLANK=2, PWM_BITS=2, STEP=2 throughout: row slot = 10 cycles, frame = 40 cycles.
1. Reset, then run 2 frames with no writes -> anode=4'b0000, cathode=4'b1111 throughout; frame_start pulses every 40 cycles, first pulse 1 cycle after reset release.
2. Write rows 0..3 = 1,2,4,8, swap_req, brightness=3 -> swap_ack 1 cycle after the frame end. Next frame, row r: 2 cycles off, then 6 cycles anode=1<<r, cathode=~(1<<r), then 2 cycles off.
3. brightness=1 and brightness=0 -> lit for exactly 2 cycles per row at brightness 1; never lit at brightness 0. Brightness changed mid-ON takes effect on the next row only.
4. swap_req pulsed 3 times within one frame -> exactly one swap_ack. swap_req on the execution cycle -> a second swap_ack one frame later.
5. wr_en to row 2 on the swap execution cycle -> the new data is visible on row 2 in the next frame. wr_row=5 (out of range, 2-bit port carries 1) hits row 1; with ROWS=3 a wr_row=3 write is ignored.
6. Assert reset during row 2 ON -> the next cycle's output is off, swap_pending is cleared, the buffers read 0, and scanning restarts at row 0 with a frame_start pulse.

Source files
------------

// File: rtl/dotmatrix_pkg.sv
// rtl/dotmatrix_pkg.sv - shared types and helpers for the dot-matrix scan driver
package dotmatrix_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // Row index width, never narrower than one bit.
  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic logic off_level(input logic on_level);
    return ~on_level;
  endfunction

endpackage

// File: rtl/dotmatrix_row_timer.sv
// rtl/dotmatrix_row_timer.sv - row slot sequencer: BLANK then PWM ON steps, row index
module dotmatrix_row_timer
  import dotmatrix_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int BLANK    = 16,
  parameter int PWM_BITS = 4,
  parameter int STEP     = 64,
  localparam int ROW_W   = row_w(ROWS)
) (
  input  logic                clock,
  input  logic                reset,
  output state_t              phase,
  output logic [PWM_BITS-1:0] step,
  output logic [ROW_W-1:0]    row,
  output logic                blank_last,
  output logic                frame_first,
  output logic                frame_end
);

  localparam int CNT_MAX = (BLANK > STEP) ? BLANK : STEP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0]    STEP_LAST  = CNT_W'(STEP - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [PWM_BITS-1:0] IDX_LAST   = '1;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [PWM_BITS-1:0] step_q, step_n;
  logic [ROW_W-1:0]    row_q, row_n;
  logic                row_adv;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_BLANK;
      cnt    <= '0;
      step_q <= '0;
      row_q  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      step_q <= step_n;
      row_q  <= row_n;
    end
  end

  // The row only advances at the end of ON, so it never changes while lit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    step_n  = step_q;
    row_n   = row_q;
    row_adv = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = ST_ON;
          cnt_n   = '0;
          step_n  = '0;
        end
      end
      ST_ON: begin
        if (cnt == STEP_LAST) begin
          cnt_n = '0;
          if (step_q == IDX_LAST) begin
            row_adv = 1'b1;
            state_n = ST_BLANK;
            step_n  = '0;
            row_n   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          end else begin
            step_n = step_q + PWM_BITS'(1);
          end
        end
      end
      default: state_n = ST_BLANK;
    endcase
  end

  assign phase       = state;
  assign step        = step_q;
  assign row         = row_q;
  assign blank_last  = (state == ST_BLANK) && (cnt == BLANK_LAST);
  assign frame_first = (state == ST_BLANK) && (cnt == '0) && (row_q == '0);
  assign frame_end   = row_adv && (row_q == ROW_LAST);

endmodule

// File: rtl/dotmatrix_scan.sv
// rtl/dotmatrix_scan.sv - double-buffered multiplexed dot-matrix scan driver with PWM
module dotmatrix_scan
  import dotmatrix_pkg::*;
#(
  parameter int   ROWS       = 8,
  parameter int   COLS       = 8,
  parameter int   BLANK      = 16,
  parameter int   PWM_BITS   = 4,
  parameter int   STEP       = 64,
  parameter logic ANODE_ON   = 1'b1,
  parameter logic CATHODE_ON = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [COLS-1:0]          wr_data,
  input  logic                     swap_req,
  output logic                     swap_ack,
  input  logic [PWM_BITS-1:0]      brightness,
  output logic [ROWS-1:0]          anode,
  output logic [COLS-1:0]          cathode,
  output logic                     frame_start
);

  localparam int   ROW_W       = row_w(ROWS);
  localparam logic ANODE_OFF   = off_level(ANODE_ON);
  localparam logic CATHODE_OFF = off_level(CATHODE_ON);

  state_t              phase;
  logic [PWM_BITS-1:0] step;
  logic [ROW_W-1:0]    row;
  logic                blank_last;
  logic                frame_first;
  logic                frame_end;

  logic [COLS-1:0]     buf0 [ROWS];
  logic [COLS-1:0]     buf1 [ROWS];
  logic                front_sel;
  logic                swap_pending;
  logic [PWM_BITS-1:0] bright_q;
  logic [COLS-1:0]     front_row;
  logic [ROWS-1:0]     anode_n;
  logic [COLS-1:0]     cathode_n;
  logic                drive;
  logic                swap_now;
  logic                wr_ok;

  dotmatrix_row_timer #(
    .ROWS     (ROWS),
    .BLANK    (BLANK),
    .PWM_BITS (PWM_BITS),
    .STEP     (STEP)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .phase       (phase),
    .step        (step),
    .row         (row),
    .blank_last  (blank_last),
    .frame_first (frame_first),
    .frame_end   (frame_end)
  );

  assign wr_ok     = wr_en && (int'(wr_row) < ROWS);
  assign swap_now  = frame_end && swap_pending;
  assign front_row = front_sel ? buf1[row] : buf0[row];
  assign drive     = (phase == ST_ON) && (step < bright_q);

  // Writes always target the buffer not being displayed this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        buf0[r] <= '0;
        buf1[r] <= '0;
      end
    end else if (wr_ok) begin
      if (front_sel) buf0[wr_row] <= wr_data;
      else           buf1[wr_row] <= wr_data;
    end
  end

  always_comb begin
    anode_n   = {ROWS{ANODE_OFF}};
    cathode_n = {COLS{CATHODE_OFF}};
    if (drive) begin
      anode_n[row] = ANODE_ON;
      for (int c = 0; c < COLS; c++) begin
        cathode_n[c] = front_row[c] ? CATHODE_ON : CATHODE_OFF;
      end
    end
  end

  // A request arriving on the swap cycle re-arms for the following frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      bright_q     <= '0;
      frame_start  <= 1'b0;
      anode        <= {ROWS{ANODE_OFF}};
      cathode      <= {COLS{CATHODE_OFF}};
    end else begin
      front_sel    <= front_sel ^ swap_now;
      swap_pending <= swap_now ? swap_req : (swap_pending | swap_req);
      swap_ack     <= swap_now;
      if (blank_last) bright_q <= brightness;
      frame_start  <= frame_first;
      anode        <= anode_n;
      cathode      <= cathode_n;
    end
  end

endmodule

// File: tb/tb_dotmatrix_scan.sv
// tb/tb_dotmatrix_scan.sv - scoreboard and table-driven bench for dotmatrix_scan
module tb_dotmatrix_scan;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [3:0] wr_data;
  logic       swap_req;
  logic [1:0] brightness;
  logic [3:0] anode4, cathode4, cathode3;
  logic [2:0] anode3;
  logic       ack4, fs4, ack3, fs3;

  always #5 clock = ~clock;

  dotmatrix_scan #(.ROWS(4), .COLS(4), .BLANK(2), .PWM_BITS(2), .STEP(2),
                   .ANODE_ON(1'b1), .CATHODE_ON(1'b0)) dut4 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(ack4), .brightness(brightness),
    .anode(anode4), .cathode(cathode4), .frame_start(fs4));

  dotmatrix_scan #(.ROWS(3), .COLS(4), .BLANK(2), .PWM_BITS(2), .STEP(2),
                   .ANODE_ON(1'b1), .CATHODE_ON(1'b0)) dut3 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(ack3), .brightness(brightness),
    .anode(anode3), .cathode(cathode3), .frame_start(fs3));

  typedef struct packed {
    logic [3:0] anode;
    logic [3:0] cathode;
    logic       ack;
    logic       fs;
  } exp_t;

  typedef struct {
    int bright;
    int exp_lit;
  } vec_t;

  exp_t       q4[$];
  exp_t       q3[$];
  logic [3:0] mbuf [2][2][4];
  int         mfront [2];
  int         mpend [2];
  int         mbr [2];
  int         mn [2];
  int         mrows [2] = '{4, 3};

  int assertions = 0;
  int failures   = 0;
  int acks_seen, lit_seen, px_seen, fs_seen;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", name, mn[0], got, exp);
    end
  endtask

  // Reference: slot = 2 blank + 4 steps x 2 cycles; frame = rows x 10.
  task automatic model_step(input int m, output exp_t e);
    int pos, row, s, last;
    bit lit;
    e = '0;
    e.cathode = 4'hF;
    if (reset) begin
      mn[m] = 0; mpend[m] = 0; mfront[m] = 0; mbr[m] = 0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 4; r++) mbuf[m][b][r] = 4'h0;
      return;
    end
    last = mrows[m] * 10 - 1;
    pos  = mn[m] % (mrows[m] * 10);
    row  = pos / 10;
    s    = pos % 10;
    if (s == 1) mbr[m] = int'(brightness);
    lit = (s >= 2) && ((s - 2) / 2 < mbr[m]);
    if (lit) begin
      e.anode   = 4'(1 << row);
      e.cathode = ~mbuf[m][mfront[m]][row];
    end
    e.fs  = (pos == 0);
    e.ack = (pos == last) && (mpend[m] != 0);
    if (wr_en && int'(wr_row) < mrows[m]) mbuf[m][1 - mfront[m]][wr_row] = wr_data;
    if (pos == last && mpend[m] != 0) begin
      mfront[m] = 1 - mfront[m];
      mpend[m]  = int'(swap_req);
    end else if (swap_req) begin
      mpend[m] = 1;
    end
    mn[m]++;
  endtask

  task automatic tick();
    exp_t e;
    model_step(0, e); q4.push_back(e);
    model_step(1, e); q3.push_back(e);
    @(posedge clock);
    @(negedge clock);
    e = q4.pop_front();
    check("dut4_pins", {22'd0, anode4, cathode4, ack4, fs4}, {22'd0, e});
    e = q3.pop_front();
    check("dut3_pins", {22'd0, 1'b0, anode3, cathode3, ack3, fs3}, {22'd0, e});
    if (ack4) acks_seen++;
    if (fs4) fs_seen++;
    if (anode4 != 4'h0) lit_seen++;
    if (anode4 != 4'h0 && cathode4 != 4'hF) px_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 40 && (mn[0] % 40) != p; i++) tick();
  endtask

  initial begin
    tbl[0] = '{3, 24};
    tbl[1] = '{2, 16};
    tbl[2] = '{1, 8};
    tbl[3] = '{0, 0};
    reset = 1'b1; wr_en = 1'b0; wr_row = 2'd0; wr_data = 4'h0;
    swap_req = 1'b0; brightness = 2'd0;
    run(3);

    // Idle frames after reset
    reset = 1'b0;
    fs_seen = 0;
    run(1);
    check("fs_first", fs4, 1'b1);
    run(79);
    check("fs_count", fs_seen, 2);

    // Load diagonal, swap, full brightness
    brightness = 2'd3;
    wr_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wr_row = 2'(r);
      wr_data = 4'(1 << r);
      run(1);
    end
    wr_en = 1'b0;
    swap_req = 1'b1; run(1); swap_req = 1'b0;
    acks_seen = 0; px_seen = 0;
    run(75);
    check("swap_ack_once", acks_seen, 1);
    check("diag_pixels", px_seen, 24);

    // Brightness table
    for (int i = 0; i < 4; i++) begin
      brightness = 2'(tbl[i].bright);
      run_to_pos(0);
      lit_seen = 0;
      run(40);
      check("lit_per_frame", lit_seen, tbl[i].exp_lit);
    end

    // Brightness change during row 0 ON applies from row 1 on
    brightness = 2'd3;
    run_to_pos(0);
    lit_seen = 0;
    run(4);
    brightness = 2'd0;
    run(36);
    check("mid_on_bright", lit_seen, 6);

    // Three requests in one frame, one swap
    run_to_pos(0);
    acks_seen = 0;
    for (int k = 0; k < 3; k++) begin
      run(5);
      swap_req = 1'b1; run(1); swap_req = 1'b0;
    end
    run(100);
    check("absorbed_reqs", acks_seen, 1);

    // Request on the execution cycle re-arms
    run_to_pos(0);
    acks_seen = 0;
    run(10);
    swap_req = 1'b1; run(1); swap_req = 1'b0;
    run_to_pos(39);
    swap_req = 1'b1; run(1); swap_req = 1'b0;
    run(40);
    check("rearm_acks", acks_seen, 2);

    // Writes: aliased row index, out-of-range row on 3-row instance, write on swap cycle
    brightness = 2'd3;
    run_to_pos(0);
    swap_req = 1'b1; run(1); swap_req = 1'b0;
    wr_en = 1'b1;
    wr_row = 2'(3'd5); wr_data = 4'b0011; run(1);
    wr_row = 2'd3;     wr_data = 4'hF;    run(1);
    wr_en = 1'b0;
    run_to_pos(39);
    wr_en = 1'b1; wr_row = 2'd2; wr_data = 4'b0101; run(1);
    wr_en = 1'b0;
    run(13);
    check("row1_alias", {anode4, cathode4}, {4'b0010, 4'b1100});
    run(10);
    check("row2_swapwr", {anode4, cathode4}, {4'b0100, 4'b1010});

    // Reset during row 2 ON with both buffers full and a swap pending
    run_to_pos(0);
    for (int pass = 0; pass < 2; pass++) begin
      wr_en = 1'b1;
      for (int r = 0; r < 4; r++) begin
        wr_row = 2'(r); wr_data = 4'hF; run(1);
      end
      wr_en = 1'b0;
      swap_req = 1'b1; run(1); swap_req = 1'b0;
      if (pass == 0) run_to_pos(0);
    end
    run_to_pos(23);
    reset = 1'b1; run(1);
    check("reset_off", {ack4, fs4, anode4, cathode4}, {1'b0, 1'b0, 4'h0, 4'hF});
    reset = 1'b0; run(1);
    check("reset_fs", fs4, 1'b1);
    acks_seen = 0; px_seen = 0;
    run(79);
    check("reset_no_pending", acks_seen, 0);
    check("reset_front_zero", px_seen, 0);
    swap_req = 1'b1; run(1); swap_req = 1'b0;
    acks_seen = 0; px_seen = 0;
    run(80);
    check("reset_swap_ack", acks_seen, 1);
    check("reset_back_zero", px_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
